// File: rtl/frame_stream_controller.sv
// frame_stream_controller: streams one IMG_W x IMG_H frame from the frame
// buffer into the first pixel_loader and counts the valid pulses that come
// back from the last pipeline stage.
// Optional drain watchdog: define FRAME_TIMEOUT_EN.
module frame_stream_controller #(
  parameter int unsigned IMG_W         = 512,
  parameter int unsigned IMG_H         = 512,
  parameter int unsigned OUT_COUNT     = 260100,
  parameter int unsigned DRAIN_TIMEOUT = 4096,
  localparam int unsigned AW = $clog2(IMG_W*IMG_H),
  localparam int unsigned CW = $clog2(OUT_COUNT+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic [7:0]    pixel_in,
  output logic          pixel_in_valid,
  input  logic          stage_out_valid,
  output logic [CW-1:0] out_count,
  output logic          busy,
  output logic          done,
  output logic          timeout
);

  localparam int unsigned NPIX = IMG_W*IMG_H;
  localparam int unsigned RW   = $clog2(NPIX+1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] out_cnt_d;
  logic [7:0]    pixel_hold_q;
  logic          issue_c;
  logic          wd_fire_c;

  // A zero watchdog limit would make DRAIN abort immediately.
  if (DRAIN_TIMEOUT == 0) begin : g_bad_drain_timeout
    $error("frame_stream_controller: DRAIN_TIMEOUT must be nonzero");
  end

  // The read strobe follows pause in the same cycle, so it is decoded here.
  assign mem_rd_en = issue_c;
  assign mem_addr  = AW'(rd_cnt_q);
  // Read data arrives one cycle after the strobe; hold the last pixel otherwise.
  assign pixel_in  = pixel_in_valid ? mem_rd_data : pixel_hold_q;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(DRAIN_TIMEOUT+1);
  logic [TW-1:0] idle_q;

  assign wd_fire_c = (state_q == S_DRAIN) && !stage_out_valid &&
                     (idle_q == TW'(DRAIN_TIMEOUT-1));

  // Cycles spent in DRAIN since the last returning valid.
  always_ff @(posedge clk) begin
    if (rst || (state_q != S_DRAIN) || stage_out_valid) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + TW'(1);
    end
  end

  // ERROR is only reachable through the watchdog, so timeout tracks it.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout <= 1'b0;
    end else begin
      timeout <= (state_d == S_ERROR);
    end
  end
`else
  assign wd_fire_c = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Next-state, read issue and returning-valid counter.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_count;
    issue_c   = 1'b0;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d   = S_FETCH;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      S_FETCH: begin
        if (!pause && (rd_cnt_q < RW'(NPIX))) begin
          issue_c  = 1'b1;
          rd_cnt_d = rd_cnt_q + RW'(1);
          if (rd_cnt_q == RW'(NPIX-1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_count == CW'(OUT_COUNT)) begin
          state_d = S_DONE;
        end else if (wd_fire_c) begin
          state_d = S_ERROR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (((state_q == S_FETCH) || (state_q == S_DRAIN)) && stage_out_valid &&
        (out_count != CW'(OUT_COUNT))) begin
      out_cnt_d = out_count + CW'(1);
    end
  end

  // State, counters and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_cnt_q  <= '0;
      out_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      out_count <= out_cnt_d;
      busy      <= (state_d == S_FETCH) || (state_d == S_DRAIN);
      done      <= (state_d == S_DONE);
    end
  end

  // Pixel qualifier and last-pixel hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_in_valid <= 1'b0;
      pixel_hold_q   <= '0;
    end else begin
      pixel_in_valid <= issue_c;
      if (pixel_in_valid) begin
        pixel_hold_q <= mem_rd_data;
      end
    end
  end

endmodule
